pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register replacing the fixed-width, hold-only stage latches between fetch/decode and decode/execute. Carries an arbitrary-width payload with a valid/ready handshake in both directions, an optional one-entry skid buffer, a flush that injects a bubble, and a freeze input from ctrl. One instance per pipeline boundary, instantiated from the core top.

---
 rtl/pipe_skid_reg_pkg.sv | 27 ++
 rtl/pipe_skid_reg_if.sv | 16 +
 rtl/pipe_skid_reg.sv | 110 +++++++++++
 tb/tb_pipe_skid_reg.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and constants for the pipeline stage register.
// Holds the stage state encoding, the default bubble payload and an occupancy helper.
package pipe_skid_reg_pkg;

  localparam int unsigned DW_DEF = 64;
  localparam int unsigned OCC_W  = 2;

  // RV32I addi x0,x0,0: what an empty or flushed stage shows downstream
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  function automatic logic [OCC_W-1:0] occ_of(input stage_state_t s);
    logic [OCC_W-1:0] n;
    case (s)
      ONE:     n = OCC_W'(1);
      TWO:     n = OCC_W'(2);
      default: n = OCC_W'(0);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready/data handshake bundle used on both sides of a pipeline stage.
// The producer owns valid/data, the consumer owns ready.
interface pipe_skid_reg_if
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional one-entry skid buffer, flush-to-bubble and freeze.
// SKID=1 breaks the ready path (in ready depends only on local state and hold).
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned   DW      = DW_DEF,
  parameter bit            SKID    = 1'b1,
  parameter logic [DW-1:0] NOP_VAL = DW'(NOP_INSN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 hold,
  pipe_skid_reg_if.slave       up,
  pipe_skid_reg_if.master      dn,
  output logic [OCC_W-1:0]     occ
);

  stage_state_t  state;
  stage_state_t  state_nxt;
  logic [DW-1:0] main_data;
  logic [DW-1:0] skid_data;

  logic main_valid;
  logic skid_valid;
  logic in_ready;
  logic out_valid;
  logic accept;
  logic take;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign up.ready = in_ready;
  assign dn.valid = out_valid;
  assign dn.data  = main_valid ? main_data : NOP_VAL;

  // Handshake qualification and next-state selection
  always_comb begin
    main_valid     = (state != EMPTY);
    skid_valid     = (state == TWO);
    out_valid      = main_valid & ~hold;
    in_ready       = 1'b0;
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    if (SKID) begin
      in_ready = ~skid_valid & ~hold;
    end else begin
      in_ready = (~main_valid | dn.ready) & ~hold;
    end

    accept = up.valid & in_ready;
    take   = out_valid & dn.ready;

    if (flush) begin
      state_nxt = EMPTY;
    end else if (!hold) begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (take && accept) begin
            load_main_in = 1'b1;
          end else if (take) begin
            state_nxt = EMPTY;
          end else if (accept && SKID) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end
        end
        TWO: begin
          if (take) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Storage; skid entry is always older than any beat accepted later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_data <= NOP_VAL;
      skid_data <= NOP_VAL;
      occ       <= '0;
    end else begin
      state <= state_nxt;
      occ   <= occ_of(state_nxt);
      if (load_main_in) begin
        main_data <= up.data;
      end else if (load_main_skid) begin
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= up.data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: one SKID=1 and one SKID=0 instance, each with a
// queue scoreboard fed on accepted beats and drained on downstream transfers.
module tb_pipe_skid_reg;

  localparam int unsigned   DW  = 64;
  localparam logic [DW-1:0] NOP = 64'h0000_0000_0000_0013;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush1, hold1, flush0, hold0;
  logic [1:0] occ1, occ0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out1   = 0;
  int n_out0   = 0;

  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] mon_e1, mon_e0;

  pipe_skid_reg_if #(.DW(DW)) up1 ();
  pipe_skid_reg_if #(.DW(DW)) dn1 ();
  pipe_skid_reg_if #(.DW(DW)) up0 ();
  pipe_skid_reg_if #(.DW(DW)) dn0 ();

  pipe_skid_reg #(.DW(DW), .SKID(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .hold(hold1),
    .up(up1), .dn(dn1), .occ(occ1)
  );

  pipe_skid_reg #(.DW(DW), .SKID(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0), .hold(hold0),
    .up(up0), .dn(dn0), .occ(occ0)
  );

  always #5 clk = ~clk;

  // Scoreboard for the skid instance: pop on take, drop on flush, push on accept
  always @(negedge clk) begin
    if (rst_n) begin
      if (dn1.valid && dn1.ready) begin
        n_out1++;
        n_checks++;
        if (exp_q1.size() == 0) begin
          $display("FAIL sb1_unexpected: got %h want no beat", dn1.data);
        end else begin
          mon_e1 = exp_q1.pop_front();
          if (dn1.data !== mon_e1) $display("FAIL sb1_data: got %h want %h", dn1.data, mon_e1);
          else n_pass++;
        end
      end
      if (flush1) exp_q1.delete();
      else if (up1.valid && up1.ready) exp_q1.push_back(up1.data);
    end
  end

  // Scoreboard for the pass-through instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (dn0.valid && dn0.ready) begin
        n_out0++;
        n_checks++;
        if (exp_q0.size() == 0) begin
          $display("FAIL sb0_unexpected: got %h want no beat", dn0.data);
        end else begin
          mon_e0 = exp_q0.pop_front();
          if (dn0.data !== mon_e0) $display("FAIL sb0_data: got %h want %h", dn0.data, mon_e0);
          else n_pass++;
        end
      end
      if (flush0) exp_q0.delete();
      else if (up0.valid && up0.ready) exp_q0.push_back(up0.data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    n_checks++; if (dn1.valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", dn1.valid); else n_pass++;
    n_checks++; if (dn1.data !== NOP) $display("FAIL rst_data: got %h want %h", dn1.data, NOP); else n_pass++;
    n_checks++; if (occ1 !== 2'd0) $display("FAIL rst_occ: got %0d want 0", occ1); else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (up1.ready !== 1'b1) $display("FAIL rst_in_ready1: got %b want 1", up1.ready); else n_pass++;
    n_checks++; if (up0.ready !== 1'b1) $display("FAIL rst_in_ready0: got %b want 1", up0.ready); else n_pass++;
  endtask

  task automatic test_stream();
    int start;
    start = n_out1;
    dn1.ready = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      up1.valid = 1'b1;
      up1.data  = 64'(i);
      #1;
      n_checks++; if (up1.ready !== 1'b1) $display("FAIL stream_ready beat %0d: got %b want 1", i, up1.ready); else n_pass++;
      tick();
      n_checks++; if (dn1.valid !== 1'b1) $display("FAIL stream_valid beat %0d: got %b want 1", i, dn1.valid); else n_pass++;
      n_checks++; if (dn1.data !== 64'(i)) $display("FAIL stream_latency beat %0d: got %h want %h", i, dn1.data, 64'(i)); else n_pass++;
      n_checks++; if (occ1 !== 2'd1) $display("FAIL stream_occ beat %0d: got %0d want 1", i, occ1); else n_pass++;
    end
    up1.valid = 1'b0;
    tick();
    n_checks++; if (occ1 !== 2'd0) $display("FAIL stream_drain_occ: got %0d want 0", occ1); else n_pass++;
    n_checks++; if (n_out1 - start !== 8) $display("FAIL stream_count: got %0d want 8", n_out1 - start); else n_pass++;
  endtask

  task automatic test_backpressure();
    int start;
    start = n_out1;
    dn1.ready = 1'b0;
    up1.valid = 1'b1;
    up1.data  = 64'hA;
    tick();
    up1.data = 64'hB;
    #1;
    n_checks++; if (up1.ready !== 1'b1) $display("FAIL bp_no_bubble: got %b want 1", up1.ready); else n_pass++;
    tick();
    up1.valid = 1'b0;
    #1;
    n_checks++; if (occ1 !== 2'd2) $display("FAIL bp_occ2: got %0d want 2", occ1); else n_pass++;
    n_checks++; if (up1.ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", up1.ready); else n_pass++;
    n_checks++; if (dn1.data !== 64'hA) $display("FAIL bp_head: got %h want a", dn1.data); else n_pass++;
    tick();
    n_checks++; if (occ1 !== 2'd2) $display("FAIL bp_occ_stall: got %0d want 2", occ1); else n_pass++;
    dn1.ready = 1'b1;
    tick();
    n_checks++; if (dn1.data !== 64'hB) $display("FAIL bp_second: got %h want b", dn1.data); else n_pass++;
    n_checks++; if (occ1 !== 2'd1) $display("FAIL bp_occ1: got %0d want 1", occ1); else n_pass++;
    tick();
    n_checks++; if (occ1 !== 2'd0) $display("FAIL bp_occ0: got %0d want 0", occ1); else n_pass++;
    n_checks++; if (n_out1 - start !== 2) $display("FAIL bp_count: got %0d want 2", n_out1 - start); else n_pass++;
  endtask

  task automatic test_flush();
    int start;
    start = n_out1;
    // Full stage flushed while upstream offers 0xC
    dn1.ready = 1'b0;
    up1.valid = 1'b1;
    up1.data  = 64'h21;
    tick();
    up1.data = 64'h22;
    tick();
    flush1   = 1'b1;
    up1.data = 64'hC;
    #1;
    n_checks++; if (up1.ready !== 1'b0) $display("FAIL flush_full_ready: got %b want 0", up1.ready); else n_pass++;
    tick();
    flush1    = 1'b0;
    up1.valid = 1'b0;
    #1;
    n_checks++; if (occ1 !== 2'd0) $display("FAIL flush_occ: got %0d want 0", occ1); else n_pass++;
    n_checks++; if (dn1.valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", dn1.valid); else n_pass++;
    n_checks++; if (dn1.data !== NOP) $display("FAIL flush_data: got %h want %h", dn1.data, NOP); else n_pass++;
    // One entry held, flush with a take and an offered beat the same cycle
    up1.valid = 1'b1;
    up1.data  = 64'h31;
    tick();
    flush1    = 1'b1;
    up1.data  = 64'hC;
    dn1.ready = 1'b1;
    #1;
    n_checks++; if (up1.ready !== 1'b1) $display("FAIL flush_one_ready: got %b want 1", up1.ready); else n_pass++;
    tick();
    flush1    = 1'b0;
    up1.valid = 1'b0;
    #1;
    n_checks++; if (occ1 !== 2'd0) $display("FAIL flush_one_occ: got %0d want 0", occ1); else n_pass++;
    tick();
    tick();
    tick();
    n_checks++; if (n_out1 - start !== 1) $display("FAIL flush_count: got %0d want 1", n_out1 - start); else n_pass++;
  endtask

  task automatic test_hold();
    int start;
    start = n_out1;
    dn1.ready = 1'b0;
    up1.valid = 1'b1;
    up1.data  = 64'hD;
    tick();
    up1.valid = 1'b0;
    hold1     = 1'b1;
    dn1.ready = 1'b1;
    #1;
    n_checks++; if (dn1.valid !== 1'b0) $display("FAIL hold_valid: got %b want 0", dn1.valid); else n_pass++;
    n_checks++; if (up1.ready !== 1'b0) $display("FAIL hold_in_ready: got %b want 0", up1.ready); else n_pass++;
    tick();
    n_checks++; if (dn1.data !== 64'hD) $display("FAIL hold_data: got %h want d", dn1.data); else n_pass++;
    n_checks++; if (occ1 !== 2'd1) $display("FAIL hold_occ: got %0d want 1", occ1); else n_pass++;
    tick();
    hold1 = 1'b0;
    #1;
    n_checks++; if (dn1.valid !== 1'b1) $display("FAIL hold_release_valid: got %b want 1", dn1.valid); else n_pass++;
    tick();
    tick();
    n_checks++; if (n_out1 - start !== 1) $display("FAIL hold_count: got %0d want 1", n_out1 - start); else n_pass++;
  endtask

  task automatic test_reset_two();
    dn1.ready = 1'b0;
    up1.valid = 1'b1;
    up1.data  = 64'h41;
    tick();
    up1.data = 64'h42;
    tick();
    up1.valid = 1'b0;
    n_checks++; if (occ1 !== 2'd2) $display("FAIL rst2_pre_occ: got %0d want 2", occ1); else n_pass++;
    rst_n = 1'b0;
    #1;
    exp_q1.delete();
    n_checks++; if (dn1.valid !== 1'b0) $display("FAIL rst2_valid: got %b want 0", dn1.valid); else n_pass++;
    n_checks++; if (dn1.data !== NOP) $display("FAIL rst2_data: got %h want %h", dn1.data, NOP); else n_pass++;
    n_checks++; if (occ1 !== 2'd0) $display("FAIL rst2_occ: got %0d want 0", occ1); else n_pass++;
    tick();
    rst_n     = 1'b1;
    dn1.ready = 1'b1;
    #1;
    n_checks++; if (up1.ready !== 1'b1) $display("FAIL rst2_in_ready: got %b want 1", up1.ready); else n_pass++;
    tick();
    n_checks++; if (dn1.valid !== 1'b0) $display("FAIL rst2_residual: got %b want 0", dn1.valid); else n_pass++;
  endtask

  task automatic test_skid0();
    int start;
    start = n_out0;
    dn0.ready = 1'b0;
    up0.valid = 1'b1;
    up0.data  = 64'hE;
    tick();
    up0.data = 64'hF;
    #1;
    n_checks++; if (up0.ready !== 1'b0) $display("FAIL s0_full_ready: got %b want 0", up0.ready); else n_pass++;
    n_checks++; if (occ0 !== 2'd1) $display("FAIL s0_occ: got %0d want 1", occ0); else n_pass++;
    dn0.ready = 1'b1;
    #1;
    n_checks++; if (up0.ready !== 1'b1) $display("FAIL s0_pass_ready: got %b want 1", up0.ready); else n_pass++;
    tick();
    n_checks++; if (dn0.data !== 64'hF) $display("FAIL s0_b2b: got %h want f", dn0.data); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      up0.data = 64'h50 + 64'(i);
      #1;
      n_checks++; if (up0.ready !== 1'b1) $display("FAIL s0_stream_ready %0d: got %b want 1", i, up0.ready); else n_pass++;
      tick();
      n_checks++; if (occ0 !== 2'd1) $display("FAIL s0_stream_occ %0d: got %0d want 1", i, occ0); else n_pass++;
    end
    up0.valid = 1'b0;
    tick();
    n_checks++; if (occ0 !== 2'd0) $display("FAIL s0_drain: got %0d want 0", occ0); else n_pass++;
    n_checks++; if (n_out0 - start !== 6) $display("FAIL s0_count: got %0d want 6", n_out0 - start); else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b1;
    flush1    = 1'b0;
    hold1     = 1'b0;
    flush0    = 1'b0;
    hold0     = 1'b0;
    up1.valid = 1'b0;
    up1.data  = '0;
    dn1.ready = 1'b0;
    up0.valid = 1'b0;
    up0.data  = '0;
    dn0.ready = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_hold();
    test_reset_two();
    test_skid0();

    tick();
    n_checks++; if (exp_q1.size() != 0) $display("FAIL sb1_leftover: got %0d want 0", exp_q1.size()); else n_pass++;
    n_checks++; if (exp_q0.size() != 0) $display("FAIL sb0_leftover: got %0d want 0", exp_q0.size()); else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
